// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse symbol sequencer.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } morse_state_e;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int MAX_SYMBOLS = 4;
    localparam int LEN_W       = 3;

endpackage

// File: rtl/morse_symbol_sequencer_if.sv
// Character output bus of the sequencer; state is exposed for observability.
import morse_pkg::*;

interface morse_symbol_sequencer_if;
    logic [MAX_SYMBOLS-1:0] code;
    logic [LEN_W-1:0]       len;
    logic                   code_valid;
    logic                   busy;
    logic [MAX_SYMBOLS-1:0] signal;
    morse_state_e           state;

    // code_valid is a one-cycle pulse with no ready; consumers must take
    // code/len in that cycle (they also hold until the next pulse).
    modport master (output code, len, code_valid, busy, signal, state);
    modport slave  (input  code, len, code_valid, busy, signal, state);
endinterface

// File: rtl/morse_debounce.sv
// Two-flop synchronizer plus debounce for one active-low button; emits a
// one-cycle pulse on the debounced released->pressed transition.
module morse_debounce #(
    parameter int DEBOUNCE_CYC = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic pressed_o,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             sync1_q, sync2_q;
    logic             level_q, press_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sync_pressed;

    assign sync_pressed = ~sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // Any cycle where the synchronized level agrees restarts the count.
            if (sync_pressed != level_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    level_q <= sync_pressed;
                    press_q <= sync_pressed;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign pressed_o = level_q;
    assign press_o   = press_q;

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Two-button Morse entry: collects up to four dot/dash symbols into a character.
// Optional MORSE_LIVE_ECHO_EN shows the in-progress buffer on signal while collecting.
import morse_pkg::*;

module morse_symbol_sequencer #(
    parameter int DEBOUNCE_CYC = 270000,
    parameter int GAP_CYC      = 35000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      button1,
    input  logic                      button2,
    morse_symbol_sequencer_if.master  out_if
);

    localparam int GAP_W = ($clog2(GAP_CYC) > 26) ? $clog2(GAP_CYC) : 26;

    logic dot_held, dot_ev, dash_held, dash_ev;

    morse_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dot (
        .clk(clk), .rst_n(rst_n), .btn_n_i(button1),
        .pressed_o(dot_held), .press_o(dot_ev)
    );

    morse_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dash (
        .clk(clk), .rst_n(rst_n), .btn_n_i(button2),
        .pressed_o(dash_held), .press_o(dash_ev)
    );

    morse_state_e           state_q;
    logic [MAX_SYMBOLS-1:0] sym_buf_q, code_q, ins_d;
    logic [LEN_W-1:0]       cnt_q, len_q;
    logic [GAP_W-1:0]       gap_q;
    logic                   code_valid_q, busy_q;
    logic                   press_any, cancel, held, sym;

    // Simultaneous dot and dash events are a cancel gesture, not a symbol.
    assign cancel    = dot_ev & dash_ev;
    assign press_any = dot_ev ^ dash_ev;
    assign sym       = dash_ev ? SYM_DASH : SYM_DOT;
    assign held      = dot_held | dash_held;
    assign ins_d     = sym_buf_q | ({{(MAX_SYMBOLS-1){1'b0}}, sym} << cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sym_buf_q    <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            code_q       <= '0;
            len_q        <= '0;
            code_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (press_any) begin
                        sym_buf_q <= {{(MAX_SYMBOLS-1){1'b0}}, sym};
                        cnt_q     <= LEN_W'(1);
                        gap_q     <= '0;
                        state_q   <= COLLECT;
                        busy_q    <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (cancel) begin
                        sym_buf_q <= '0;
                        cnt_q     <= '0;
                        gap_q     <= '0;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end else if (press_any) begin
                        sym_buf_q <= ins_d;
                        cnt_q     <= cnt_q + 1'b1;
                        gap_q     <= '0;
                        if (cnt_q == LEN_W'(MAX_SYMBOLS - 1)) begin
                            state_q      <= EMIT;
                            code_q       <= ins_d;
                            len_q        <= cnt_q + 1'b1;
                            code_valid_q <= 1'b1;
                        end
                    end else if (held) begin
                        gap_q <= '0;
                    end else if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                        // Output registers load on entry so code_valid is high during EMIT.
                        state_q      <= EMIT;
                        code_q       <= sym_buf_q;
                        len_q        <= cnt_q;
                        code_valid_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                EMIT: begin
                    gap_q <= '0;
                    if (press_any) begin
                        sym_buf_q <= {{(MAX_SYMBOLS-1){1'b0}}, sym};
                        cnt_q     <= LEN_W'(1);
                        state_q   <= COLLECT;
                        busy_q    <= 1'b1;
                    end else begin
                        sym_buf_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_if.code       = code_q;
    assign out_if.len        = len_q;
    assign out_if.code_valid = code_valid_q;
    assign out_if.busy       = busy_q;
    assign out_if.state      = state_q;

`ifdef MORSE_LIVE_ECHO_EN
    // Buffer bits at or above the count are always zero, so no masking is needed.
    assign out_if.signal = (state_q == COLLECT) ? sym_buf_q : code_q;
`else
    assign out_if.signal = code_q;
`endif

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Directed bench for morse_symbol_sequencer with DEBOUNCE_CYC=4, GAP_CYC=20.
import morse_pkg::*;

module tb_morse_symbol_sequencer;

  localparam int DEB = 4;
  localparam int GAP = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button1 = 1'b1;
  logic button2 = 1'b1;

  int checks = 0;
  int errors = 0;
  int emit_cnt = 0;

  morse_symbol_sequencer_if bus_if ();

  morse_symbol_sequencer #(.DEBOUNCE_CYC(DEB), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .button1(button1), .button2(button2), .out_if(bus_if)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (bus_if.code_valid === 1'b1) emit_cnt++;

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tap(input bit b1, input bit b2, input int low, input int high);
    button1 = b1 ? 1'b0 : 1'b1;
    button2 = b2 ? 1'b0 : 1'b1;
    cyc(low);
    button1 = 1'b1;
    button2 = 1'b1;
    cyc(high);
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus_if.code_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (bus_if.code !== 4'd0) begin errors++; $display("FAIL rst_code got %b exp 0000", bus_if.code); end
    checks++; if (bus_if.len !== 3'd0) begin errors++; $display("FAIL rst_len got %0d exp 0", bus_if.len); end
    checks++; if (bus_if.code_valid !== 1'b0 || bus_if.busy !== 1'b0) begin errors++; $display("FAIL rst_flags got v=%b b=%b exp 0 0", bus_if.code_valid, bus_if.busy); end
    checks++; if (bus_if.signal !== 4'd0 || bus_if.state !== IDLE) begin errors++; $display("FAIL rst_sig_state got %b %0d exp 0000 IDLE", bus_if.signal, bus_if.state); end
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
  endtask

  task automatic test_gap_close();
    bit ok;
    int base;
    base = emit_cnt;
    tap(1, 0, 10, 8);
    tap(0, 1, 10, 8);
    tap(1, 0, 10, 8);
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL gap_busy_collect got %b exp 1", bus_if.busy); end
    wait_valid(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL gap_timeout got no code_valid exp pulse"); end
    checks++; if (bus_if.code !== 4'b0010 || bus_if.len !== 3'd3) begin errors++; $display("FAIL gap_char got %b/%0d exp 0010/3", bus_if.code, bus_if.len); end
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL gap_busy_emit got %b exp 1", bus_if.busy); end
    checks++; if (bus_if.signal !== 4'b0010) begin errors++; $display("FAIL gap_signal got %b exp 0010", bus_if.signal); end
    @(negedge clk);
    checks++; if (bus_if.busy !== 1'b0 || bus_if.code_valid !== 1'b0) begin errors++; $display("FAIL gap_after got b=%b v=%b exp 0 0", bus_if.busy, bus_if.code_valid); end
    cyc(30);
    checks++; if (emit_cnt - base !== 1) begin errors++; $display("FAIL gap_emits got %0d exp 1", emit_cnt - base); end
  endtask

  task automatic test_four_symbols();
    int first;
    int base;
    base = emit_cnt;
    first = 0;
    tap(0, 1, 10, 8);
    tap(0, 1, 10, 8);
    tap(0, 1, 10, 8);
    button2 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus_if.code_valid === 1'b1 && first == 0) first = i;
    end
    checks++; if (first != DEB + 4) begin errors++; $display("FAIL four_latency got %0d exp %0d", first, DEB + 4); end
    checks++; if (bus_if.code !== 4'b1111 || bus_if.len !== 3'd4) begin errors++; $display("FAIL four_char got %b/%0d exp 1111/4", bus_if.code, bus_if.len); end
    @(posedge clk); #1;
    button2 = 1'b1;
    cyc(40);
    checks++; if (emit_cnt - base !== 1) begin errors++; $display("FAIL four_emits got %0d exp 1", emit_cnt - base); end
  endtask

  task automatic test_cancel();
    int base;
    base = emit_cnt;
    tap(1, 0, 10, 8);
    checks++; if (bus_if.state !== COLLECT) begin errors++; $display("FAIL cancel_pre_state got %0d exp COLLECT", bus_if.state); end
    tap(1, 1, 10, 40);
    checks++; if (emit_cnt != base) begin errors++; $display("FAIL cancel_emits got %0d exp 0", emit_cnt - base); end
    checks++; if (bus_if.state !== IDLE || bus_if.busy !== 1'b0) begin errors++; $display("FAIL cancel_state got %0d b=%b exp IDLE 0", bus_if.state, bus_if.busy); end
    checks++; if (bus_if.code !== 4'b1111 || bus_if.len !== 3'd4) begin errors++; $display("FAIL cancel_hold got %b/%0d exp 1111/4", bus_if.code, bus_if.len); end
  endtask

  task automatic test_bounce();
    bit ok;
    int base;
    base = emit_cnt;
    for (int i = 0; i < 6; i++) begin
      button1 = (i % 2 == 0) ? 1'b0 : 1'b1;
      cyc(2);
    end
    tap(1, 0, 10, 0);
    wait_valid(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bounce_timeout got no code_valid exp pulse"); end
    checks++; if (bus_if.code !== 4'b0000 || bus_if.len !== 3'd1) begin errors++; $display("FAIL bounce_char got %b/%0d exp 0000/1", bus_if.code, bus_if.len); end
    cyc(30);
    checks++; if (emit_cnt - base !== 1) begin errors++; $display("FAIL bounce_emits got %0d exp 1", emit_cnt - base); end
  endtask

  task automatic test_press_in_emit();
    bit ok;
    int base;
    base = emit_cnt;
    tap(0, 1, 10, 8);
    tap(1, 0, 10, 8);
    tap(1, 0, 10, 8);
    button2 = 1'b0;
    cyc(1);
    button1 = 1'b0;
    wait_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL emitpress_timeout got no code_valid exp pulse"); end
    checks++; if (bus_if.code !== 4'b1001 || bus_if.len !== 3'd4) begin errors++; $display("FAIL emitpress_char got %b/%0d exp 1001/4", bus_if.code, bus_if.len); end
    @(negedge clk);
    checks++; if (bus_if.state !== COLLECT || bus_if.busy !== 1'b1) begin errors++; $display("FAIL emitpress_next got %0d b=%b exp COLLECT 1", bus_if.state, bus_if.busy); end
    @(posedge clk); #1;
    button1 = 1'b1;
    button2 = 1'b1;
    wait_valid(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL emitpress_timeout2 got no code_valid exp pulse"); end
    checks++; if (bus_if.code !== 4'b0000 || bus_if.len !== 3'd1) begin errors++; $display("FAIL emitpress_char2 got %b/%0d exp 0000/1", bus_if.code, bus_if.len); end
    cyc(30);
    checks++; if (emit_cnt - base !== 2) begin errors++; $display("FAIL emitpress_emits got %0d exp 2", emit_cnt - base); end
  endtask

  task automatic test_async_reset();
    int base;
    base = emit_cnt;
    button1 = 1'b0;
    cyc(8);
    checks++; if (bus_if.state !== COLLECT) begin errors++; $display("FAIL arst_pre_state got %0d exp COLLECT", bus_if.state); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.len !== 3'd0 || bus_if.code !== 4'd0) begin errors++; $display("FAIL arst_char got %b/%0d exp 0000/0", bus_if.code, bus_if.len); end
    checks++; if (bus_if.busy !== 1'b0 || bus_if.state !== IDLE || bus_if.signal !== 4'd0) begin errors++; $display("FAIL arst_state got b=%b s=%0d sig=%b exp 0 IDLE 0000", bus_if.busy, bus_if.state, bus_if.signal); end
    button1 = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(50);
    checks++; if (emit_cnt != base || bus_if.state !== IDLE) begin errors++; $display("FAIL arst_after got emits=%0d s=%0d exp 0 IDLE", emit_cnt - base, bus_if.state); end
  endtask

  initial begin
    test_reset();
    test_gap_close();
    test_four_symbols();
    test_cancel();
    test_bounce();
    test_press_in_emit();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
